// File: rtl/snn_interfaces_pkg.sv
// Shared types for the SNN feature-map controllers.
// Scheduler state encoding, output bundle and parameter defaults.
package snn_interfaces_pkg;

  typedef enum logic [2:0] {
    S_CONV       = 3'd0,
    S_DRAIN      = 3'd1,
    S_POOL_START = 3'd2,
    S_POOL_RUN   = 3'd3,
    S_POOL_PAUSE = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic arb_sel_conv;
    logic conv_hold;
    logic pool_start;
    logic pool_enable;
  } sched_out_t;

  localparam int DEFAULT_MAX_PENDING   = 4;
  localparam int DEFAULT_DRAIN_TIMEOUT = 1024;

  localparam sched_out_t SCHED_OUT_RESET = '{
    arb_sel_conv: 1'b1,
    conv_hold:    1'b0,
    pool_start:   1'b0,
    pool_enable:  1'b0
  };

  function automatic logic in_pool_phase(sched_state_t s);
    return (s == S_POOL_RUN) || (s == S_POOL_PAUSE);
  endfunction

endpackage

// File: rtl/conv_pool_scheduler_if.sv
// Control bus between the scheduler and the conv, pool and arbiter blocks.
// The scheduler is the master; the datapath side is the slave.
interface conv_pool_scheduler_if;

  logic conv_active;
  logic conv_ready;
  logic conv_hold;
  logic pool_start;
  logic pool_enable;
  logic pool_done;
  logic output_fifo_full;
  logic arb_sel_conv;

  modport master (
    input  conv_active,
    input  conv_ready,
    input  pool_done,
    input  output_fifo_full,
    output conv_hold,
    output pool_start,
    output pool_enable,
    output arb_sel_conv
  );

  modport slave (
    output conv_active,
    output conv_ready,
    output pool_done,
    output output_fifo_full,
    input  conv_hold,
    input  pool_start,
    input  pool_enable,
    input  arb_sel_conv
  );

endinterface

// File: rtl/timestep_accumulator.sv
// Timestep period counter feeding a bounded pending-request count,
// with saturating drop accounting and a sticky overflow flag.
module timestep_accumulator
  import snn_interfaces_pkg::*;
#(
  parameter int MAX_PENDING   = DEFAULT_MAX_PENDING,
  parameter int PENDING_BITS  = $clog2(MAX_PENDING + 1),
  parameter int PERIOD_BITS   = 4,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sys_enable,
  input  logic                     sys_reset,
  input  logic                     timestep,
  input  logic [PERIOD_BITS-1:0]   cfg_pool_every,
  input  logic                     dequeue,
  output logic [PENDING_BITS-1:0]  pending_cnt,
  output logic [DROP_CNT_BITS-1:0] dropped_cnt,
  output logic                     overflow
);

  localparam logic [PENDING_BITS-1:0] FULL_LVL =
    PENDING_BITS'(MAX_PENDING);

  logic [PERIOD_BITS-1:0] period_cnt;
  logic [PERIOD_BITS:0]   period;
  logic [PERIOD_BITS:0]   period_nxt;
  logic                   hit;
  logic                   deq;
  logic                   full;
  logic                   enq;
  logic                   drop;

  // >= lets a shortened period take effect on the very next pulse
  always_comb begin
    period     = (cfg_pool_every == '0)
               ? (PERIOD_BITS+1)'(1)
               : {1'b0, cfg_pool_every};
    period_nxt = {1'b0, period_cnt} + 1'b1;
    hit        = sys_enable && timestep
              && (period_nxt >= period);
    deq        = sys_enable && dequeue
              && (pending_cnt != '0);
    full       = pending_cnt == FULL_LVL;
    enq        = hit && (!full || deq);
    drop       = hit && full && !deq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt  <= '0;
      pending_cnt <= '0;
      dropped_cnt <= '0;
      overflow    <= 1'b0;
    end else if (sys_reset) begin
      period_cnt  <= '0;
      pending_cnt <= '0;
      dropped_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (sys_enable && timestep)
        period_cnt <= hit ? '0
                    : period_nxt[PERIOD_BITS-1:0];
      if (enq && !deq)
        pending_cnt <= pending_cnt + 1'b1;
      else if (deq && !enq)
        pending_cnt <= pending_cnt - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_cnt != '1)
          dropped_cnt <= dropped_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_pool_scheduler.sv
// Arbitrates feature-map ownership between conv and sum-pooling,
// with queued pool requests, back-to-back passes and a drain watchdog.
module conv_pool_scheduler
  import snn_interfaces_pkg::*;
#(
  parameter int MAX_PENDING   = DEFAULT_MAX_PENDING,
  parameter int PENDING_BITS  = $clog2(MAX_PENDING + 1),
  parameter int PERIOD_BITS   = 4,
  parameter int DROP_CNT_BITS = 8,
  parameter int POOL_CNT_BITS = 16,
  parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT,
  parameter int TIMEOUT_BITS  = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sys_enable,
  input  logic                     sys_reset,
  input  logic                     timestep,
  input  logic [PERIOD_BITS-1:0]   cfg_pool_every,
  conv_pool_scheduler_if.master    bus,
  output logic [2:0]               state_o,
  output logic [PENDING_BITS-1:0]  pending_cnt,
  output logic [POOL_CNT_BITS-1:0] pool_pass_cnt,
  output logic [DROP_CNT_BITS-1:0] ts_dropped_cnt,
  output logic                     ts_overflow,
  output logic                     drain_timeout
);

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX =
    TIMEOUT_BITS'(DRAIN_TIMEOUT);

  sched_state_t            state;
  sched_state_t            state_nxt;
  sched_state_t            state_eff;
  sched_out_t              out_q;
  sched_out_t              out_d;
  logic                    conv_idle;
  logic                    in_pool;
  logic                    dequeue;
  logic                    run_ok;
  logic                    has_pending;
  logic [TIMEOUT_BITS-1:0] wd_cnt;

  assign conv_idle   = bus.conv_ready && !bus.conv_active;
  assign in_pool     = in_pool_phase(state);
  assign dequeue     = state == S_POOL_START;
  assign run_ok      = sys_enable && !sys_reset;
  assign has_pending = pending_cnt != '0;

  timestep_accumulator #(
    .MAX_PENDING   (MAX_PENDING),
    .PENDING_BITS  (PENDING_BITS),
    .PERIOD_BITS   (PERIOD_BITS),
    .DROP_CNT_BITS (DROP_CNT_BITS)
  ) u_acc (
    .clk            (clk),
    .rst_n          (rst_n),
    .sys_enable     (sys_enable),
    .sys_reset      (sys_reset),
    .timestep       (timestep),
    .cfg_pool_every (cfg_pool_every),
    .dequeue        (dequeue),
    .pending_cnt    (pending_cnt),
    .dropped_cnt    (ts_dropped_cnt),
    .overflow       (ts_overflow)
  );

  // outputs are registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CONV;
      out_q <= SCHED_OUT_RESET;
    end else begin
      state <= state_eff;
      out_q <= out_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_CONV:
        if (has_pending)
          state_nxt = conv_idle ? S_POOL_START : S_DRAIN;
      S_DRAIN:
        if (conv_idle)
          state_nxt = S_POOL_START;
      S_POOL_START:
        state_nxt = S_POOL_RUN;
      S_POOL_RUN:
        if (bus.pool_done)
          state_nxt = has_pending ? S_POOL_START : S_CONV;
        else if (bus.output_fifo_full)
          state_nxt = S_POOL_PAUSE;
      S_POOL_PAUSE:
        if (bus.pool_done)
          state_nxt = has_pending ? S_POOL_START : S_CONV;
        else if (!bus.output_fifo_full)
          state_nxt = S_POOL_RUN;
      default:
        state_nxt = S_CONV;
    endcase
  end

  always_comb begin
    state_eff = state;
    if (sys_reset)
      state_eff = S_CONV;
    else if (sys_enable)
      state_eff = state_nxt;
    out_d              = '0;
    out_d.arb_sel_conv = (state_eff == S_CONV)
                      || (state_eff == S_DRAIN);
    out_d.conv_hold    = state_eff != S_CONV;
    out_d.pool_start   = run_ok
                      && (state_eff == S_POOL_START);
    out_d.pool_enable  = run_ok
                      && (state_eff == S_POOL_RUN)
                      && !bus.output_fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_pass_cnt <= '0;
      wd_cnt        <= '0;
      drain_timeout <= 1'b0;
    end else if (sys_reset) begin
      pool_pass_cnt <= '0;
      wd_cnt        <= '0;
      drain_timeout <= 1'b0;
    end else if (sys_enable) begin
      if (in_pool && bus.pool_done)
        pool_pass_cnt <= pool_pass_cnt + 1'b1;
      if (state == S_DRAIN && state_nxt == S_DRAIN) begin
        if (wd_cnt != WD_MAX)
          wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_MAX - 1'b1)
          drain_timeout <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign state_o          = state;
  assign bus.arb_sel_conv = out_q.arb_sel_conv;
  assign bus.conv_hold    = out_q.conv_hold;
  assign bus.pool_start   = out_q.pool_start;
  assign bus.pool_enable  = out_q.pool_enable;

endmodule

// File: tb/tb_conv_pool_scheduler.sv
// Directed bench for conv_pool_scheduler.
// Inputs change and outputs are sampled on the falling edge.
module tb_conv_pool_scheduler;
  import snn_interfaces_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys_enable;
  logic        sys_reset;
  logic        timestep;
  logic [3:0]  cfg_pool_every;
  logic [2:0]  state_o;
  logic [2:0]  pending_cnt;
  logic [15:0] pool_pass_cnt;
  logic [7:0]  ts_dropped_cnt;
  logic        ts_overflow;
  logic        drain_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  conv_pool_scheduler_if bus ();

  conv_pool_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sys_enable     (sys_enable),
    .sys_reset      (sys_reset),
    .timestep       (timestep),
    .cfg_pool_every (cfg_pool_every),
    .bus            (bus.master),
    .state_o        (state_o),
    .pending_cnt    (pending_cnt),
    .pool_pass_cnt  (pool_pass_cnt),
    .ts_dropped_cnt (ts_dropped_cnt),
    .ts_overflow    (ts_overflow),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse_ts();
    timestep = 1'b1;
    tick(1);
    timestep = 1'b0;
  endtask

  initial begin
    rst_n                = 1'b0;
    sys_enable           = 1'b1;
    sys_reset            = 1'b0;
    timestep             = 1'b0;
    cfg_pool_every       = 4'd1;
    bus.conv_active      = 1'b0;
    bus.conv_ready       = 1'b1;
    bus.pool_done        = 1'b0;
    bus.output_fifo_full = 1'b0;
    tick(2);
    chk("rst_state", state_o, 32'd0);
    chk("rst_arb", bus.arb_sel_conv, 32'd1);
    chk("rst_hold", bus.conv_hold, 32'd0);
    chk("rst_start", bus.pool_start, 32'd0);
    chk("rst_en", bus.pool_enable, 32'd0);
    chk("rst_pend", pending_cnt, 32'd0);
    chk("rst_pass", pool_pass_cnt, 32'd0);
    chk("rst_drop", ts_dropped_cnt, 32'd0);
    chk("rst_ovf", ts_overflow, 32'd0);
    chk("rst_wdt", drain_timeout, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // single timestep, cfg=1, conv idle
    pulse_ts();
    chk("t1_pend1", pending_cnt, 32'd1);
    chk("t1_conv", state_o, 32'd0);
    tick(1);
    chk("t1_pstart_st", state_o, 32'd2);
    chk("t1_pstart", bus.pool_start, 32'd1);
    chk("t1_arb0", bus.arb_sel_conv, 32'd0);
    chk("t1_hold", bus.conv_hold, 32'd1);
    tick(1);
    chk("t1_run", state_o, 32'd3);
    chk("t1_pstart0", bus.pool_start, 32'd0);
    chk("t1_en", bus.pool_enable, 32'd1);
    chk("t1_pend0", pending_cnt, 32'd0);
    bus.pool_done = 1'b1;
    tick(1);
    bus.pool_done = 1'b0;
    chk("t1_back", state_o, 32'd0);
    chk("t1_pass", pool_pass_cnt, 32'd1);
    chk("t1_arb1", bus.arb_sel_conv, 32'd1);
    chk("t1_en0", bus.pool_enable, 32'd0);

    // cfg=3, seven pulses while conv busy
    cfg_pool_every = 4'd3;
    bus.conv_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pulse_ts();
      tick(1);
    end
    chk("t2_pend", pending_cnt, 32'd2);
    chk("t2_period", dut.u_acc.period_cnt, 32'd1);
    chk("t2_drain", state_o, 32'd1);
    chk("t2_hold", bus.conv_hold, 32'd1);
    chk("t2_arb", bus.arb_sel_conv, 32'd1);
    bus.conv_ready = 1'b1;
    tick(1);
    chk("t2_start", state_o, 32'd2);
    tick(1);
    bus.pool_done = 1'b1;
    tick(1);
    bus.pool_done = 1'b0;
    chk("t2_b2b", state_o, 32'd2);
    chk("t2_pass", pool_pass_cnt, 32'd2);
    chk("t2_b2b_ps", bus.pool_start, 32'd1);
    tick(1);
    chk("t2_pend0", pending_cnt, 32'd0);

    // six pulses during a stalled pass overflow the queue
    cfg_pool_every = 4'd1;
    timestep = 1'b1;
    tick(6);
    timestep = 1'b0;
    chk("t3_pend", pending_cnt, 32'd4);
    chk("t3_drop", ts_dropped_cnt, 32'd2);
    chk("t3_ovf", ts_overflow, 32'd1);
    chk("t3_run", state_o, 32'd3);
    bus.pool_done = 1'b1;
    tick(1);
    bus.pool_done = 1'b0;
    chk("t3_start", state_o, 32'd2);
    pulse_ts();
    chk("t3_coinc_pend", pending_cnt, 32'd4);
    chk("t3_coinc_drop", ts_dropped_cnt, 32'd2);
    for (int i = 0; i < 2; i++) begin
      bus.pool_done = 1'b1;
      tick(1);
      bus.pool_done = 1'b0;
      tick(1);
    end
    chk("t6_pend2", pending_cnt, 32'd2);
    chk("t6_run", state_o, 32'd3);

    // synchronous clear mid-pass
    sys_reset = 1'b1;
    tick(1);
    sys_reset = 1'b0;
    chk("t6_state", state_o, 32'd0);
    chk("t6_pend", pending_cnt, 32'd0);
    chk("t6_pass", pool_pass_cnt, 32'd0);
    chk("t6_drop", ts_dropped_cnt, 32'd0);
    chk("t6_ovf", ts_overflow, 32'd0);
    chk("t6_arb", bus.arb_sel_conv, 32'd1);
    chk("t6_en", bus.pool_enable, 32'd0);
    tick(1);
    chk("t6_nostart", bus.pool_start, 32'd0);

    // backpressure and freeze during a pass
    pulse_ts();
    tick(2);
    chk("t5_run", state_o, 32'd3);
    bus.output_fifo_full = 1'b1;
    tick(1);
    chk("t5_pause", state_o, 32'd4);
    chk("t5_en0", bus.pool_enable, 32'd0);
    bus.output_fifo_full = 1'b0;
    tick(1);
    chk("t5_resume", state_o, 32'd3);
    chk("t5_en1", bus.pool_enable, 32'd1);
    sys_enable = 1'b0;
    tick(1);
    chk("t5_frz_en", bus.pool_enable, 32'd0);
    chk("t5_frz_st", state_o, 32'd3);
    sys_enable = 1'b1;
    bus.output_fifo_full = 1'b1;
    tick(1);
    chk("t5_pause2", state_o, 32'd4);
    bus.pool_done = 1'b1;
    tick(1);
    bus.pool_done = 1'b0;
    bus.output_fifo_full = 1'b0;
    chk("t5_done", state_o, 32'd0);
    chk("t5_pass", pool_pass_cnt, 32'd1);

    // drain watchdog
    bus.conv_active = 1'b1;
    pulse_ts();
    tick(1);
    chk("t4_drain", state_o, 32'd1);
    tick(1023);
    chk("t4_wdt0", drain_timeout, 32'd0);
    tick(1);
    chk("t4_wdt1", drain_timeout, 32'd1);
    tick(6);
    chk("t4_still", state_o, 32'd1);
    chk("t4_hold", bus.conv_hold, 32'd1);
    bus.conv_active = 1'b0;
    tick(1);
    chk("t4_release", state_o, 32'd2);
    chk("t4_sticky", drain_timeout, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
